// File: rtl/riscv_csr_pkg.sv
// CSR address map and operation encodings
// shared by the Riscv151 CSR file.
package riscv_csr_pkg;

  localparam logic [11:0] CSR_TOHOST       = 12'h51E;
  localparam logic [11:0] CSR_SCRATCH_BASE = 12'h7C0;
  localparam logic [11:0] CSR_CYCLE        = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH       = 12'hC80;
  localparam logic [11:0] CSR_INSTRET      = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH     = 12'hC82;

  typedef enum logic [1:0] {
    CSR_NOP = 2'b00,
    CSR_RW  = 2'b01,
    CSR_RS  = 2'b10,
    CSR_RC  = 2'b11
  } csr_op_e;

endpackage

// File: rtl/csr_event_fifo.sv
// Synchronous log FIFO with valid/ready drain;
// extra pointer bit separates full from empty.
module csr_event_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  input  logic             ready,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             pop;
  logic             wr;

  assign valid = wptr != rptr;
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop   = valid & ready;
  // A pop frees the slot the push lands in
  assign wr    = push & (!full | pop);
  assign data  = valid ? mem[rptr[AW-1:0]] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr)  wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/riscv_csr_file.sv
// Zicsr register file: tohost with write log,
// scratch CSRs, 64-bit cycle/instret counters.
module riscv_csr_file
  import riscv_csr_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int NUM_SCRATCH  = 4,
  parameter int TOHOST_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            csr_en,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic            csr_src_zero,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            instret_inc,
  output logic [XLEN-1:0] tohost_value,
  output logic            tohost_valid,
  output logic [XLEN-1:0] tohost_data,
  input  logic            tohost_ready,
  output logic            tohost_overflow
);

  csr_op_e                op;
  logic                   hit_tohost;
  logic                   hit_ro;
  logic                   mapped;
  logic                   wr_try;
  logic                   we;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   ovf_q;
  logic [NUM_SCRATCH-1:0] scr_sel;
  logic [XLEN-1:0]        old_val;
  logic [XLEN-1:0]        new_val;
  logic [XLEN-1:0]        tohost_q;
  logic [XLEN-1:0]        scratch_q [NUM_SCRATCH];
  logic [63:0]            cycle_q;
  logic [63:0]            instret_q;

  assign op = csr_op_e'(csr_op);

  always_comb begin
    old_val    = '0;
    hit_tohost = 1'b0;
    hit_ro     = 1'b0;
    scr_sel    = '0;
    case (csr_addr)
      CSR_TOHOST: begin
        hit_tohost = 1'b1;
        old_val    = tohost_q;
      end
      CSR_CYCLE: begin
        hit_ro  = 1'b1;
        old_val = cycle_q[31:0];
      end
      CSR_CYCLEH: begin
        hit_ro  = 1'b1;
        old_val = cycle_q[63:32];
      end
      CSR_INSTRET: begin
        hit_ro  = 1'b1;
        old_val = instret_q[31:0];
      end
      CSR_INSTRETH: begin
        hit_ro  = 1'b1;
        old_val = instret_q[63:32];
      end
      default: ;
    endcase
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      if (csr_addr == CSR_SCRATCH_BASE + 12'(i)) begin
        scr_sel[i] = 1'b1;
        old_val    = scratch_q[i];
      end
    end
  end

  always_comb begin
    new_val = old_val;
    unique case (op)
      CSR_NOP: new_val = old_val;
      CSR_RW:  new_val = csr_wdata;
      CSR_RS:  new_val = old_val | csr_wdata;
      CSR_RC:  new_val = old_val & ~csr_wdata;
    endcase
  end

  // RS/RC with a zero source is a pure read
  assign wr_try = (op == CSR_RW) ||
                  ((op != CSR_NOP) && !csr_src_zero);
  assign mapped = hit_tohost | hit_ro | (|scr_sel);
  assign we     = csr_en & wr_try & mapped & !hit_ro;

  assign csr_illegal = csr_en &
                       (!mapped | (hit_ro & wr_try));
  assign csr_rdata   = old_val;

  assign push = we & hit_tohost;
  assign pop  = tohost_valid & tohost_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tohost_q  <= '0;
      cycle_q   <= '0;
      instret_q <= '0;
      ovf_q     <= 1'b0;
      for (int i = 0; i < NUM_SCRATCH; i++)
        scratch_q[i] <= '0;
    end else begin
      cycle_q <= cycle_q + 64'd1;
      if (instret_inc)
        instret_q <= instret_q + 64'd1;
      if (we && hit_tohost)
        tohost_q <= new_val;
      for (int i = 0; i < NUM_SCRATCH; i++)
        if (we && scr_sel[i])
          scratch_q[i] <= new_val;
      if (push && full && !pop)
        ovf_q <= 1'b1;
    end
  end

  assign tohost_value    = tohost_q;
  assign tohost_overflow = ovf_q;

  csr_event_fifo #(
    .WIDTH (XLEN),
    .DEPTH (TOHOST_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (new_val),
    .valid     (tohost_valid),
    .data      (tohost_data),
    .ready     (tohost_ready),
    .full      (full)
  );

endmodule

// File: tb/tb_riscv_csr_file.sv
// Directed bench for riscv_csr_file with
// immediate assertions at each check point.
module tb_riscv_csr_file;

  logic        clk;
  logic        rst_n;
  logic        csr_en;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_src_zero;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        instret_inc;
  logic [31:0] tohost_value;
  logic        tohost_valid;
  logic [31:0] tohost_data;
  logic        tohost_ready;
  logic        tohost_overflow;

  int errors = 0;
  int checks = 0;
  int tb_cycles;

  localparam logic [1:0] NOP = 2'b00;
  localparam logic [1:0] RW  = 2'b01;
  localparam logic [1:0] RS  = 2'b10;
  localparam logic [1:0] RC  = 2'b11;

  riscv_csr_file dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .csr_en          (csr_en),
    .csr_op          (csr_op),
    .csr_addr        (csr_addr),
    .csr_wdata       (csr_wdata),
    .csr_src_zero    (csr_src_zero),
    .csr_rdata       (csr_rdata),
    .csr_illegal     (csr_illegal),
    .instret_inc     (instret_inc),
    .tohost_value    (tohost_value),
    .tohost_valid    (tohost_valid),
    .tohost_data     (tohost_data),
    .tohost_ready    (tohost_ready),
    .tohost_overflow (tohost_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) tb_cycles <= 0;
    else        tb_cycles <= tb_cycles + 1;

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(input logic en,
                       input logic [1:0] op,
                       input logic [11:0] a,
                       input logic [31:0] wd,
                       input logic sz);
    csr_en       = en;
    csr_op       = op;
    csr_addr     = a;
    csr_wdata    = wd;
    csr_src_zero = sz;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int drain1[3] = '{100, 116, 16};
    int drain2[4] = '{2, 3, 4, 6};

    rst_n        = 1'b0;
    instret_inc  = 1'b0;
    tohost_ready = 1'b0;
    drive(0, NOP, 12'h000, 0, 0);
    #1;
    chk("rst_tohost", tohost_value, 0);
    chk("rst_valid", {31'd0, tohost_valid}, 0);
    chk("rst_ovf", {31'd0, tohost_overflow}, 0);
    chk("rst_data", tohost_data, 0);

    tick;
    rst_n = 1'b1;
    drive(0, NOP, 12'hC00, 0, 0);
    chk("cycle_first", csr_rdata, 0);
    tick;
    chk("cycle_second", csr_rdata, 1);
    drive(0, RW, 12'h123, 1, 0);
    chk("illegal_no_en", {31'd0, csr_illegal}, 0);

    // tohost RMW chain, log retained
    drive(1, RW, 12'h51E, 100, 0);
    chk("rw_old", csr_rdata, 0);
    chk("rw_legal", {31'd0, csr_illegal}, 0);
    tick;
    chk("val_100", tohost_value, 100);
    drive(1, RS, 12'h51E, 16, 0);
    chk("rs_old", csr_rdata, 100);
    tick;
    chk("val_116", tohost_value, 116);
    chk("log_vis_valid", {31'd0, tohost_valid}, 1);
    chk("log_vis_data", tohost_data, 100);
    drive(1, RC, 12'h51E, 100, 0);
    chk("rc_old", csr_rdata, 116);
    tick;
    chk("val_16", tohost_value, 16);
    drive(0, NOP, 12'h51E, 0, 0);
    tohost_ready = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("drain1_valid", {31'd0, tohost_valid}, 1);
      chk("drain1_data", tohost_data, drain1[i]);
      tick;
    end
    chk("drain1_empty", {31'd0, tohost_valid}, 0);

    // no bypass on empty
    drive(1, RW, 12'h51E, 42, 0);
    chk("nobyp_pre", {31'd0, tohost_valid}, 0);
    tick;
    drive(0, NOP, 12'h51E, 0, 0);
    chk("nobyp_valid", {31'd0, tohost_valid}, 1);
    chk("nobyp_data", tohost_data, 42);
    tick;
    chk("nobyp_popped", {31'd0, tohost_valid}, 0);

    // read-only counters
    drive(1, RW, 12'hC00, 5, 0);
    chk("ro_rw_illegal", {31'd0, csr_illegal}, 1);
    chk("ro_rw_rdata", csr_rdata, tb_cycles);
    tick;
    drive(1, RS, 12'hC00, 0, 1);
    chk("ro_rs0_legal", {31'd0, csr_illegal}, 0);
    chk("ro_rs0_rdata", csr_rdata, tb_cycles);
    drive(1, RC, 12'hC80, 3, 0);
    chk("ro_rc_illegal", {31'd0, csr_illegal}, 1);
    drive(0, NOP, 12'hC02, 0, 0);
    instret_inc = 1'b1;
    tick;
    tick;
    tick;
    instret_inc = 1'b0;
    drive(1, RS, 12'hC02, 0, 1);
    chk("instret_lo", csr_rdata, 3);
    drive(1, RS, 12'hC82, 0, 1);
    chk("instret_hi", csr_rdata, 0);

    // overflow at depth 4, then full push+pop
    tohost_ready = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      drive(1, RW, 12'h51E, v, 0);
      tick;
    end
    drive(0, NOP, 12'h51E, 0, 0);
    chk("ovf_valid", {31'd0, tohost_valid}, 1);
    chk("ovf_head", tohost_data, 1);
    chk("ovf_flag", {31'd0, tohost_overflow}, 1);
    chk("ovf_value", tohost_value, 5);
    tohost_ready = 1'b1;
    drive(1, RW, 12'h51E, 6, 0);
    tick;
    drive(0, NOP, 12'h51E, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk("drain2_valid", {31'd0, tohost_valid}, 1);
      chk("drain2_data", tohost_data, drain2[i]);
      tick;
    end
    chk("drain2_empty", {31'd0, tohost_valid}, 0);
    chk("ovf_sticky", {31'd0, tohost_overflow}, 1);

    // scratch CSRs
    for (int i = 0; i < 4; i++) begin
      drive(1, RW, 12'h7C0 + 12'(i), i + 1, 0);
      tick;
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, RS, 12'h7C0 + 12'(i), 0, 1);
      chk("scr_read", csr_rdata, i + 1);
      chk("scr_legal", {31'd0, csr_illegal}, 0);
    end
    drive(1, RS, 12'h7C1, 8, 0);
    tick;
    drive(0, NOP, 12'h7C1, 0, 0);
    chk("scr_rs", csr_rdata, 10);
    drive(1, RW, 12'h7C4, 9, 0);
    chk("scr_oob_ill", {31'd0, csr_illegal}, 1);
    chk("scr_oob_rd", csr_rdata, 0);
    drive(1, RW, 12'h123, 9, 0);
    chk("unmap_ill", {31'd0, csr_illegal}, 1);
    chk("unmap_rd", csr_rdata, 0);

    // 64-bit cycle wrap
    drive(0, NOP, 12'hC00, 0, 0);
    force dut.cycle_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.cycle_q;
    chk("wrap_pre_lo", csr_rdata, 32'hFFFF_FFFF);
    csr_addr = 12'hC80;
    #1;
    chk("wrap_pre_hi", csr_rdata, 32'hFFFF_FFFF);
    tick;
    chk("wrap_hi", csr_rdata, 0);
    csr_addr = 12'hC00;
    #1;
    chk("wrap_lo", csr_rdata, 0);

    // asynchronous reset mid-sequence
    tohost_ready = 1'b0;
    drive(1, RW, 12'h51E, 9, 0);
    tick;
    drive(1, RW, 12'h51E, 77, 0);
    chk("prerst_valid", {31'd0, tohost_valid}, 1);
    chk("prerst_ovf", {31'd0, tohost_overflow}, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_tohost", tohost_value, 0);
    chk("arst_valid", {31'd0, tohost_valid}, 0);
    chk("arst_data", tohost_data, 0);
    chk("arst_ovf", {31'd0, tohost_overflow}, 0);
    chk("arst_rdata", csr_rdata, 0);
    tick;
    rst_n = 1'b1;
    drive(0, NOP, 12'hC00, 0, 0);
    chk("post_rst_val", tohost_value, 0);
    chk("post_rst_cyc", csr_rdata, 0);
    chk("post_rst_vld", {31'd0, tohost_valid}, 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
